// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared key codes and state encodings for the lock controller
package lock_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam logic [3:0] KEY_BKSP  = 4'hC;

  typedef enum logic [1:0] {
    ENTRY_IDLE    = 2'b00,
    ENTRY_COLLECT = 2'b01,
    ENTRY_HOLD    = 2'b10
  } entry_state_t;

  typedef enum logic [2:0] {
    LOCK_LOCKED = 3'd0,
    LOCK_VERIFY = 3'd1,
    LOCK_OPEN   = 3'd2,
    LOCK_ALARM  = 3'd3
  } lock_state_t;

endpackage

// File: rtl/code_entry_if.sv
// rtl/code_entry_if.sv - keypad strobe and code handshake bundle between keypad, code_entry and lock FSM
interface code_entry_if #(
  parameter int DIGITS  = 4,
  parameter int DIGIT_W = 4
);
  localparam int LEN_W = $clog2(DIGITS + 1);

  logic                      key_valid;
  logic [DIGIT_W-1:0]        key_code;
  logic                      code_ack;
  logic [DIGITS*DIGIT_W-1:0] code;
  logic [LEN_W-1:0]          code_len;
  logic                      code_valid;
  logic                      entry_active;
  logic                      timeout;
  logic                      key_reject;

  modport master (
    output key_valid, key_code, code_ack,
    input  code, code_len, code_valid, entry_active, timeout, key_reject
  );

  modport slave (
    input  key_valid, key_code, code_ack,
    output code, code_len, code_valid, entry_active, timeout, key_reject
  );
endinterface

// File: rtl/entry_timer.sv
// rtl/entry_timer.sv - inter-key idle timer; expired is high on the last idle cycle before discard
module entry_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // cnt_q counts idle edges since the last accepted key, so TIMEOUT_CYC-1 means this edge is the last
  assign expired = run && (cnt_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || !run || expired) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/code_entry.sv
// rtl/code_entry.sv - keypad code collector with timeout and valid/ack handoff to the lock FSM
// Optional BACKSPACE key (0xC) enabled by CODE_ENTRY_BACKSPACE_EN.
module code_entry
  import lock_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int DIGIT_W     = lock_pkg::DIGIT_W,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic         clk,
  input  logic         reset,
  code_entry_if.slave  bus
);
  localparam int LEN_W = $clog2(DIGITS + 1);
  localparam int BUF_W = DIGITS * DIGIT_W;
  localparam logic [LEN_W-1:0] FULL = LEN_W'(DIGITS);

  entry_state_t     state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             active_q, active_d;
  logic             timeout_q, timeout_d;
  logic             reject_q, reject_d;
  logic             tmr_clear, tmr_expired;
  logic             is_digit, is_clear, is_enter, is_bksp;

  assign is_digit = bus.key_code < DIGIT_W'(10);
  assign is_clear = bus.key_code == DIGIT_W'(KEY_CLEAR);
  assign is_enter = bus.key_code == DIGIT_W'(KEY_ENTER);
`ifdef CODE_ENTRY_BACKSPACE_EN
  assign is_bksp  = bus.key_code == DIGIT_W'(KEY_BKSP);
`else
  assign is_bksp  = 1'b0;
`endif

  entry_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .run     (state_q == ENTRY_COLLECT),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    reject_d  = 1'b0;
    timeout_d = 1'b0;
    tmr_clear = 1'b0;
    case (state_q)
      ENTRY_IDLE: begin
        if (bus.key_valid) begin
          if (is_digit) begin
            buf_d     = BUF_W'(bus.key_code);
            cnt_d     = LEN_W'(1);
            state_d   = (cnt_d == FULL) ? ENTRY_HOLD : ENTRY_COLLECT;
            tmr_clear = 1'b1;
          end else if (!is_clear) begin
            reject_d = 1'b1;
          end
        end
      end
      ENTRY_COLLECT: begin
        // An accepted key on the expiry edge takes priority over the timeout
        if (bus.key_valid && (is_digit || is_enter || is_clear || is_bksp)) begin
          tmr_clear = 1'b1;
          if (is_digit) begin
            buf_d = (buf_q << DIGIT_W) | BUF_W'(bus.key_code);
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == FULL) state_d = ENTRY_HOLD;
          end else if (is_enter) begin
            state_d = ENTRY_HOLD;
          end else if (is_clear) begin
            buf_d   = '0;
            cnt_d   = '0;
            state_d = ENTRY_IDLE;
          end else begin
            buf_d = buf_q >> DIGIT_W;
            cnt_d = cnt_q - 1'b1;
            if (cnt_d == '0) state_d = ENTRY_IDLE;
          end
        end else begin
          reject_d = bus.key_valid;
          if (tmr_expired) begin
            timeout_d = 1'b1;
            buf_d     = '0;
            cnt_d     = '0;
            state_d   = ENTRY_IDLE;
          end
        end
      end
      ENTRY_HOLD: begin
        reject_d = bus.key_valid;
        if (bus.code_ack) begin
          buf_d   = '0;
          cnt_d   = '0;
          state_d = ENTRY_IDLE;
        end
      end
      default: begin
        buf_d   = '0;
        cnt_d   = '0;
        state_d = ENTRY_IDLE;
      end
    endcase
    valid_d  = (state_d == ENTRY_HOLD);
    active_d = (state_d == ENTRY_COLLECT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ENTRY_IDLE;
      buf_q     <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
      timeout_q <= 1'b0;
      reject_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
      timeout_q <= timeout_d;
      reject_q  <= reject_d;
    end
  end

  assign bus.code         = buf_q;
  assign bus.code_len     = cnt_q;
  assign bus.code_valid   = valid_q;
  assign bus.entry_active = active_q;
  assign bus.timeout      = timeout_q;
  assign bus.key_reject   = reject_q;
endmodule

// File: tb/tb_code_entry.sv
// tb/tb_code_entry.sv - directed self-checking bench for code_entry (DIGITS=4, TIMEOUT_CYC=8)
module tb_code_entry;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  code_entry_if #(.DIGITS(4), .DIGIT_W(4)) bus ();

  code_entry #(.DIGITS(4), .DIGIT_W(4), .TIMEOUT_CYC(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ack();
    bus.code_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.code_ack = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.code_ack  = 1'b0;
    #12;
    chk("rst_code", 32'(bus.code), 32'h0);
    chk("rst_len", 32'(bus.code_len), 32'h0);
    chk("rst_valid", 32'(bus.code_valid), 32'h0);
    chk("rst_active", 32'(bus.entry_active), 32'h0);
    chk("rst_timeout", 32'(bus.timeout), 32'h0);
    chk("rst_reject", 32'(bus.key_reject), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    idle(1);

    // IDLE key handling and stray ack
    press(4'hB);
    chk("idle_enter_reject", 32'(bus.key_reject), 32'h1);
    press(4'hA);
    chk("idle_clear_noreject", 32'(bus.key_reject), 32'h0);
    chk("idle_clear_active", 32'(bus.entry_active), 32'h0);
    ack();
    chk("idle_ack_ignored", 32'(bus.code_valid), 32'h0);

    // Test 1: auto-submit on 4th digit
    press(4'h1);
    chk("t1_active", 32'(bus.entry_active), 32'h1);
    chk("t1_code1", 32'(bus.code), 32'h0001);
    press(4'h2);
    press(4'h3);
    chk("t1_valid_early", 32'(bus.code_valid), 32'h0);
    press(4'h4);
    chk("t1_valid", 32'(bus.code_valid), 32'h1);
    chk("t1_code", 32'(bus.code), 32'h1234);
    chk("t1_len", 32'(bus.code_len), 32'h4);
    chk("t1_active_hold", 32'(bus.entry_active), 32'h0);
    ack();
    chk("t1_ack_valid", 32'(bus.code_valid), 32'h0);
    chk("t1_ack_code", 32'(bus.code), 32'h0);
    chk("t1_ack_len", 32'(bus.code_len), 32'h0);

    // Test 2: ENTER submit and reject in HOLD
    press(4'h7);
    press(4'h8);
    press(4'hB);
    chk("t2_code", 32'(bus.code), 32'h0078);
    chk("t2_len", 32'(bus.code_len), 32'h2);
    chk("t2_valid", 32'(bus.code_valid), 32'h1);
    press(4'h5);
    chk("t2_hold_reject", 32'(bus.key_reject), 32'h1);
    chk("t2_hold_code", 32'(bus.code), 32'h0078);
    idle(1);
    chk("t2_reject_pulse", 32'(bus.key_reject), 32'h0);
    ack();

    // Test 3: CLEAR mid-entry
    press(4'h9);
    press(4'hA);
    chk("t3_clear_active", 32'(bus.entry_active), 32'h0);
    chk("t3_clear_len", 32'(bus.code_len), 32'h0);
    press(4'h3);
    press(4'hB);
    chk("t3_code", 32'(bus.code), 32'h0003);
    chk("t3_len", 32'(bus.code_len), 32'h1);
    ack();

    // Test 4: timeout exactly 8 edges after key, reserved key does not restart timer
    press(4'h5);
    idle(3);
    press(4'hF);
    chk("t4_reserved_reject", 32'(bus.key_reject), 32'h1);
    idle(3);
    chk("t4_no_timeout_yet", 32'(bus.timeout), 32'h0);
    chk("t4_still_active", 32'(bus.entry_active), 32'h1);
    idle(1);
    chk("t4_timeout", 32'(bus.timeout), 32'h1);
    chk("t4_len", 32'(bus.code_len), 32'h0);
    chk("t4_active", 32'(bus.entry_active), 32'h0);
    idle(1);
    chk("t4_timeout_pulse", 32'(bus.timeout), 32'h0);
    press(4'h5);
    idle(7);
    press(4'h6);
    chk("t4b_no_timeout", 32'(bus.timeout), 32'h0);
    chk("t4b_code", 32'(bus.code), 32'h0056);
    chk("t4b_active", 32'(bus.entry_active), 32'h1);
    press(4'hA);

    // Test 5: asynchronous reset mid-entry
    press(4'h1);
    press(4'h2);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_code", 32'(bus.code), 32'h0);
    chk("t5_len", 32'(bus.code_len), 32'h0);
    chk("t5_valid", 32'(bus.code_valid), 32'h0);
    chk("t5_active", 32'(bus.entry_active), 32'h0);
    #3;
    reset = 1'b0;
    idle(1);
    press(4'h9);
    chk("t5_after_code", 32'(bus.code), 32'h0009);
    chk("t5_after_len", 32'(bus.code_len), 32'h1);
    press(4'hA);

    // Test 6: key 0xC
    press(4'h4);
    press(4'h5);
    press(4'hC);
`ifdef CODE_ENTRY_BACKSPACE_EN
    chk("t6_bksp_reject", 32'(bus.key_reject), 32'h0);
    chk("t6_bksp_code", 32'(bus.code), 32'h0004);
    press(4'h6);
    press(4'hB);
    chk("t6_code", 32'(bus.code), 32'h0046);
    chk("t6_len", 32'(bus.code_len), 32'h2);
`else
    chk("t6_bksp_reject", 32'(bus.key_reject), 32'h1);
    chk("t6_bksp_code", 32'(bus.code), 32'h0045);
    press(4'h6);
    press(4'hB);
    chk("t6_code", 32'(bus.code), 32'h0456);
    chk("t6_len", 32'(bus.code_len), 32'h3);
`endif
    chk("t6_valid", 32'(bus.code_valid), 32'h1);
    ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
